// File: rtl/acc_readout_if.sv
// Handshake/bus bundle between the readout sequencer, the accumulator array,
// the UART TX and the command controller.
interface acc_readout_if #(
    parameter int SEL_W = 4
) ();
    logic             start;
    logic             busy;
    logic [7:0]       acc_byte;
    logic [SEL_W-1:0] sel;
    logic [7:0]       tx_data;
    logic             send;
    logic             out;
    logic             clear;
    logic             done;

    modport master (
        input  start, busy, acc_byte,
        output sel, tx_data, send, out, clear, done
    );

    modport slave (
        output start, busy, acc_byte,
        input  sel, tx_data, send, out, clear, done
    );
endinterface

// File: rtl/acc_readout_seq.sv
// Reads the accumulator array byte by byte out over the UART TX, then clears it.
// Optional trailing XOR checksum byte when READOUT_CHECKSUM_EN is defined.
module acc_readout_seq #(
    parameter int NUM_BYTES   = 16,
    parameter int SEL_W       = 4,
    parameter int SETTLE      = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    acc_readout_if.master bus
);
    localparam int CNT_MAX = (SETTLE > ACK_TIMEOUT) ? SETTLE : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_BYTES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOAD,
        ST_SEND,
        ST_ACK,
        ST_DRAIN,
        ST_NEXT,
`ifdef READOUT_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_FINISH
    } state_t;

    state_t           state_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [7:0]       tx_data_reg;
    logic             send_reg;
    logic             out_reg;
    logic             clear_reg;
    logic             done_reg;
    logic [CNT_W-1:0] cnt_reg;
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]       xor_reg;
    logic             cksum_sent_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= '0;
            tx_data_reg    <= '0;
            send_reg       <= 1'b0;
            out_reg        <= 1'b0;
            clear_reg      <= 1'b0;
            done_reg       <= 1'b0;
            cnt_reg        <= '0;
`ifdef READOUT_CHECKSUM_EN
            xor_reg        <= '0;
            cksum_sent_reg <= 1'b0;
`endif
        end else begin
            send_reg  <= 1'b0;
            clear_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg      <= ST_SETTLE;
                        out_reg        <= 1'b1;
                        sel_reg        <= '0;
                        cnt_reg        <= '0;
`ifdef READOUT_CHECKSUM_EN
                        xor_reg        <= '0;
                        cksum_sent_reg <= 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == CNT_W'(SETTLE - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_LOAD;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_LOAD: begin
                    tx_data_reg <= bus.acc_byte;
`ifdef READOUT_CHECKSUM_EN
                    xor_reg     <= xor_reg ^ bus.acc_byte;
`endif
                    state_reg   <= ST_SEND;
                end
                ST_SEND: begin
                    // A TX still busy with the previous byte defers the pulse,
                    // so each byte gets exactly one send.
                    if (!bus.busy) begin
                        send_reg  <= 1'b1;
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (bus.busy || (cnt_reg >= CNT_W'(ACK_TIMEOUT))) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.busy) begin
                        state_reg <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
`ifdef READOUT_CHECKSUM_EN
                    if (cksum_sent_reg) begin
                        state_reg <= ST_FINISH;
                    end else if (sel_reg == LAST_SEL) begin
                        state_reg <= ST_CKSUM;
                    end else begin
                        sel_reg   <= sel_reg + 1'b1;
                        state_reg <= ST_LOAD;
                    end
`else
                    if (sel_reg == LAST_SEL) begin
                        state_reg <= ST_FINISH;
                    end else begin
                        sel_reg   <= sel_reg + 1'b1;
                        state_reg <= ST_LOAD;
                    end
`endif
                end
`ifdef READOUT_CHECKSUM_EN
                ST_CKSUM: begin
                    tx_data_reg    <= xor_reg;
                    cksum_sent_reg <= 1'b1;
                    state_reg      <= ST_SEND;
                end
`endif
                ST_FINISH: begin
                    clear_reg <= 1'b1;
                    done_reg  <= 1'b1;
                    out_reg   <= 1'b0;
                    sel_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel     = sel_reg;
    assign bus.tx_data = tx_data_reg;
    assign bus.send    = send_reg;
    assign bus.out     = out_reg;
    assign bus.clear   = clear_reg;
    assign bus.done    = done_reg;
endmodule

// File: tb/tb_acc_readout_seq.sv
// Self-checking bench for acc_readout_seq: table of readout scenarios against a
// byte-list reference model, plus a hand-written mid-readout reset sequence.
module tb_acc_readout_seq;
    localparam int NB = 16;
    localparam int SW = 4;
    localparam int ST = 2;
    localparam int AT = 15;
    localparam int BUDGET = 3000;
`ifdef READOUT_CHECKSUM_EN
    localparam int EXP_SENDS = NB + 1;
`else
    localparam int EXP_SENDS = NB;
`endif

    typedef struct {
        int resp_len;   // busy high-time after each send, 0 = TX never acks
        bit hold;       // busy held high for 50 cycles around start
        int pattern;    // 0: 8'h10+sel, 1: random, 2: 8'h5A at sel 3 only
        bit stray;      // extra start from 5th byte through FINISH
        int exp_sends;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_readout_if #(.SEL_W(SW)) bus_if ();

    acc_readout_seq #(
        .NUM_BYTES(NB), .SEL_W(SW), .SETTLE(ST), .ACK_TIMEOUT(AT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    logic [7:0] acc_mem [NB];
    assign bus_if.acc_byte = acc_mem[bus_if.sel];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART TX model: busy rises one cycle after a send and stays up resp_len cycles
    int resp_len = 10;
    int hold_until = 0;
    int resp_cnt = 0;
    bit pend = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            resp_cnt = 0;
            pend = 1'b0;
        end else begin
            if (resp_cnt > 0) resp_cnt = resp_cnt - 1;
            if (pend) begin
                resp_cnt = resp_len;
                pend = 1'b0;
            end
            if (bus_if.send && resp_len > 0) pend = 1'b1;
        end
        bus_if.busy = (cyc < hold_until) || (resp_cnt > 0);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [7:0] got [$];
    int send_cyc [$];
    int n_done;
    int max_sel;

    task automatic step();
        @(negedge clk);
        if (bus_if.send) begin
            got.push_back(bus_if.tx_data);
            send_cyc.push_back(cyc);
            $display("cycle %0d: send #%0d sel=%0d tx_data=%02h", cyc, got.size(), bus_if.sel, bus_if.tx_data);
            if (got.size() == 1) chk("out_active_at_first_send", bus_if.out, 1);
        end
        if (bus_if.done) begin
            n_done++;
            $display("cycle %0d: done, clear=%0b out=%0b", cyc, bus_if.clear, bus_if.out);
            chk("clear_with_done", bus_if.clear, 1);
            chk("out_low_at_done", bus_if.out, 0);
        end
        if (bus_if.clear) chk("done_with_clear", bus_if.done, 1);
        if (int'(bus_if.sel) > max_sel) max_sel = int'(bus_if.sel);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] exp_q [$];
        logic [7:0] x;
        int start_cyc;
        int post;
        int d;
        for (int i = 0; i < NB; i++) begin
            case (v.pattern)
                0: acc_mem[i] = 8'h10 + 8'(i);
                1: acc_mem[i] = 8'($urandom);
                default: acc_mem[i] = (i == 3) ? 8'h5A : 8'h00;
            endcase
        end
        // reference model: bytes in select order, then their XOR if enabled
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(acc_mem[i]);
            x = x ^ acc_mem[i];
        end
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        got.delete();
        send_cyc.delete();
        n_done = 0;
        max_sel = 0;
        resp_len = v.resp_len;
        hold_until = v.hold ? cyc + 50 : 0;
        step();
        bus_if.start = 1'b1;
        start_cyc = cyc;
        step();
        bus_if.start = 1'b0;
        post = -1;
        for (int k = 0; k < BUDGET; k++) begin
            step();
            if (v.stray && got.size() >= 5 && n_done == 0) bus_if.start = 1'b1;
            if (n_done > 0) bus_if.start = 1'b0;
            if (n_done > 0) post++;
            if (post >= 30) break;
        end
        bus_if.start = 1'b0;
        chk($sformatf("v%0d_completed", idx), post >= 30, 1);
        chk($sformatf("v%0d_send_count", idx), got.size(), v.exp_sends);
        chk($sformatf("v%0d_done_count", idx), n_done, v.exp_done);
        chk($sformatf("v%0d_sel_max", idx), max_sel, NB - 1);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("v%0d_byte%0d", idx, i), got[i], exp_q[i]);
        if (got.size() > 0) begin
            if (v.hold) chk($sformatf("v%0d_first_send_after_busy", idx), send_cyc[0], hold_until + 1);
            else chk($sformatf("v%0d_first_send_latency", idx), send_cyc[0] - (start_cyc + 1), ST + 2);
        end
        if (v.resp_len == 0) begin
            for (int i = 1; i < send_cyc.size(); i++) begin
                d = send_cyc[i] - send_cyc[i-1];
                chk($sformatf("v%0d_timeout_gap%0d(%0d)", idx, i, d), (d >= AT && d <= AT + 6), 1);
            end
        end
        chk($sformatf("v%0d_out_idle_after", idx), bus_if.out, 0);
    endtask

    vec_t vecs [7];
    int rst_sends;

    initial begin
        vecs[0] = '{resp_len: 10, hold: 0, pattern: 0, stray: 0, exp_sends: EXP_SENDS, exp_done: 1};
        vecs[1] = '{resp_len: 10, hold: 1, pattern: 0, stray: 0, exp_sends: EXP_SENDS, exp_done: 1};
        vecs[2] = '{resp_len: 0,  hold: 0, pattern: 0, stray: 0, exp_sends: EXP_SENDS, exp_done: 1};
        vecs[3] = '{resp_len: 10, hold: 0, pattern: 1, stray: 1, exp_sends: EXP_SENDS, exp_done: 1};
        vecs[4] = '{resp_len: int'($urandom_range(1, 12)), hold: 0, pattern: 2, stray: 0, exp_sends: EXP_SENDS, exp_done: 1};
        vecs[5] = '{resp_len: int'($urandom_range(1, 12)), hold: 0, pattern: 1, stray: 0, exp_sends: EXP_SENDS, exp_done: 1};
        vecs[6] = '{resp_len: int'($urandom_range(0, 12)), hold: 0, pattern: 1, stray: 0, exp_sends: EXP_SENDS, exp_done: 1};

        for (int i = 0; i < NB; i++) acc_mem[i] = 8'h00;
        bus_if.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_sel", bus_if.sel, 0);
        chk("reset_tx_data", bus_if.tx_data, 0);
        chk("reset_send", bus_if.send, 0);
        chk("reset_out", bus_if.out, 0);
        chk("reset_clear", bus_if.clear, 0);
        chk("reset_done", bus_if.done, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // mid-readout reset: abort after the 7th send, then a fresh full readout
        for (int i = 0; i < NB; i++) acc_mem[i] = 8'h10 + 8'(i);
        resp_len = 10;
        hold_until = 0;
        got.delete();
        send_cyc.delete();
        step();
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        for (int k = 0; k < BUDGET && got.size() < 7; k++) step();
        chk("rst_seq_reached_7_sends", got.size(), 7);
        rst = 1'b1;
        $display("cycle %0d: reset asserted mid-readout", cyc);
        step();
        chk("midrst_sel", bus_if.sel, 0);
        chk("midrst_tx_data", bus_if.tx_data, 0);
        chk("midrst_send", bus_if.send, 0);
        chk("midrst_out", bus_if.out, 0);
        chk("midrst_clear", bus_if.clear, 0);
        chk("midrst_done", bus_if.done, 0);
        step();
        rst = 1'b0;
        rst_sends = got.size();
        repeat (30) step();
        chk("no_send_after_reset", got.size(), rst_sends);
        run_vec(vecs[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
